idex_pipe_reg: RTL

- Parametrised ID/EX pipeline register for the MIPS-style pipelined datapath. It sits between decode (register file, sign-extend, control unit) and execute (ALU, jump/branch logic).
- Adds what the earlier stage register lacked:
  - a valid bit;
  - stall (hold) and flush (kill) controls;
  - built-in load-use hazard detection with automatic bubble insertion;
  - a saturating bubble counter for performance debug.

---
 rtl/idex_pipe_reg.sv | 106 ++++++++++
 1 files changed

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with valid bit, stall/flush control, load-use hazard
// detection with automatic bubble insertion, and a saturating bubble counter.
module idex_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 3,
  parameter int JADDR_W = 26,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               id_uses_rt,
  input  logic               wb_regwrite_in,
  input  logic               wb_memtoreg_in,
  input  logic               m_branch_in,
  input  logic               m_memread_in,
  input  logic               m_memwrite_in,
  input  logic               ex_regdst_in,
  input  logic               ex_alusrc_in,
  input  logic               jump_in,
  input  logic [ALUOP_W-1:0] ex_aluop_in,
  input  logic [DATA_W-1:0]  pc4_in,
  input  logic [DATA_W-1:0]  rdata1_in,
  input  logic [DATA_W-1:0]  rdata2_in,
  input  logic [DATA_W-1:0]  sext_in,
  input  logic [REG_W-1:0]   rt_in,
  input  logic [REG_W-1:0]   rd_in,
  input  logic [JADDR_W-1:0] jaddr_in,
  output logic               wb_regwrite_out,
  output logic               wb_memtoreg_out,
  output logic               m_branch_out,
  output logic               m_memread_out,
  output logic               m_memwrite_out,
  output logic               ex_regdst_out,
  output logic               ex_alusrc_out,
  output logic               jump_out,
  output logic [ALUOP_W-1:0] ex_aluop_out,
  output logic [DATA_W-1:0]  pc4_out,
  output logic [DATA_W-1:0]  rdata1_out,
  output logic [DATA_W-1:0]  rdata2_out,
  output logic [DATA_W-1:0]  sext_out,
  output logic [REG_W-1:0]   rt_out,
  output logic [REG_W-1:0]   rd_out,
  output logic [JADDR_W-1:0] jaddr_out,
  output logic               ex_valid,
  output logic               hazard_stall,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam int CTL_W = 8 + ALUOP_W;
  localparam int DAT_W = 4 * DATA_W + 2 * REG_W + JADDR_W;

  logic [CTL_W-1:0] ctlIn, ctlQ;
  logic [DAT_W-1:0] datIn, datQ;
  logic             validQ;
  logic [CNT_W-1:0] cntQ;
  logic             rtHit;

  assign ctlIn = {wb_regwrite_in, wb_memtoreg_in, m_branch_in, m_memread_in,
                  m_memwrite_in, ex_regdst_in, ex_alusrc_in, jump_in, ex_aluop_in};
  assign datIn = {pc4_in, rdata1_in, rdata2_in, sext_in, rt_in, rd_in, jaddr_in};

  assign {wb_regwrite_out, wb_memtoreg_out, m_branch_out, m_memread_out,
          m_memwrite_out, ex_regdst_out, ex_alusrc_out, jump_out, ex_aluop_out} = ctlQ;
  assign {pc4_out, rdata1_out, rdata2_out, sext_out, rt_out, rd_out, jaddr_out} = datQ;
  assign ex_valid   = validQ;
  assign bubble_cnt = cntQ;

  // $0 is hard-wired, so a load targeting it can never feed a dependent read.
  assign rtHit = (rt_out != '0) &&
                 ((rt_out == id_rs) || (id_uses_rt && (rt_out == id_rt)));
  assign hazard_stall = !flush && validQ && m_memread_out && id_valid && rtHit;

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // blocking assignments would let later statements see the new value early.
  always_ff @(posedge clk) begin
    if (rst) begin
      validQ <= 1'b0;
      ctlQ   <= '0;
      datQ   <= '0;
      cntQ   <= '0;
    end else if (flush) begin
      validQ <= 1'b0;
      ctlQ   <= '0;
      datQ   <= datIn;
    end else if (!stall) begin
      if (hazard_stall) begin
        // Bubble: kill controls, keep data so the held load stays visible.
        validQ <= 1'b0;
        ctlQ   <= '0;
        if (~&cntQ)
          cntQ <= cntQ + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        validQ <= id_valid;
        ctlQ   <= id_valid ? ctlIn : '0;
        datQ   <= datIn;
      end
    end
  end

endmodule
